// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN (adds the dropped-beat counter).
package stream_demux_pkg;

    // Packet-tracking FSM: IDLE = no packet open, PKT = packet locked to cur_sel.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    // Width of the dropped-beat counter; it saturates at all-ones.
    localparam int DROP_CNT_W = 16;

    // Select width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one input stream, N_OUT output streams.
// slave = the demux's view, master = the environment's view (source + sinks).
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN (the counter is a plain port, not part of this bundle).
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = sel_width(N_OUT)
);

    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_last;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_ready;

    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_last;
    logic [N_OUT-1:0]        out_ready;

    modport slave (
        input  in_data, in_valid, in_last, in_sel, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, in_last, in_sel, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/stream_demux_out_reg.sv
// One-entry output register for a single demux channel.
// Supports load, drain, and load-while-draining (the new beat wins, valid stays high).
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN (not used by this module).
module demux_out_reg #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    // Hold one beat; a load takes priority over a drain in the same cycle.
    // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            last  <= ld_last;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream demultiplexer.
// The select is sampled on a packet's first beat and held until in_last; an out-of-range
// select swallows the whole packet. Each channel has a one-entry register and the input
// only stalls when the current target register is full and not being drained.
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN (adds the saturating drop_cnt port).
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = sel_width(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_demux_if.slave         bus
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    // Channel count in select width plus one bit, so the range test cannot overflow.
    localparam logic [SEL_W:0] N_OUT_V = (SEL_W + 1)'(N_OUT);

    state_t                        state;
    logic [SEL_W-1:0]              cur_sel;
    logic [SEL_W-1:0]              tgt;
    logic                          drop;
    logic [N_OUT-1:0]              tgt_oh;
    logic                          tgt_free;
    logic                          in_ready;
    logic                          accept;
    logic [N_OUT-1:0]              load;
    logic [N_OUT-1:0]              reg_valid;
    logic [N_OUT-1:0]              reg_last;
    logic [N_OUT-1:0][DATA_W-1:0]  reg_data;

    // Mid-packet beats follow the latched channel; a packet start follows in_sel.
    assign tgt  = (state == ST_PKT) ? cur_sel : bus.in_sel;
    assign drop = ({1'b0, tgt} >= N_OUT_V);

    // Decode the target channel into a one-hot vector.
    // NOTE: default assignment first so no path leaves tgt_oh unassigned (no latch).
    always_comb begin
        tgt_oh = '0;
        for (int k = 0; k < N_OUT; k++) begin
            tgt_oh[k] = (tgt == SEL_W'(k));
        end
    end

    // Target can take a beat if empty or draining this cycle; dropped packets always flow.
    assign tgt_free     = |(tgt_oh & (~reg_valid | bus.out_ready));
    assign in_ready     = rst_n & (drop | tgt_free);
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid & in_ready;
    assign load         = tgt_oh & {N_OUT{accept & ~drop}};

    // Track packet boundaries and latch the destination on a multi-beat packet start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cur_sel <= '0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (!bus.in_last) begin
                        state   <= ST_PKT;
                        cur_sel <= bus.in_sel;
                    end
                end
                ST_PKT: begin
                    if (bus.in_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        demux_out_reg #(
            .DATA_W (DATA_W)
        ) u_reg (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .ld_data (bus.in_data),
            .ld_last (bus.in_last),
            .drain   (bus.out_ready[k]),
            .valid   (reg_valid[k]),
            .data    (reg_data[k]),
            .last    (reg_last[k])
        );
    end

    assign bus.out_valid = reg_valid;
    assign bus.out_last  = reg_last;
    assign bus.out_data  = reg_data;

`ifdef STREAM_DEMUX_DROP_CNT_EN
    // Count accepted beats of dropped packets, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (DATA_W=4, N_OUT=3 so an out-of-range select exists).
// A per-beat reference model predicts in_ready, per-channel contents and the drop count.
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN (drop_cnt is also compared when defined).
module tb_stream_demux;
    import stream_demux_pkg::*;

    localparam int DATA_W = 4;
    localparam int N_OUT  = 3;
    localparam int SEL_W  = sel_width(N_OUT);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(DATA_W), .N_OUT(N_OUT), .SEL_W(SEL_W)) bus ();

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt;
`endif

    stream_demux #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT),
        .SEL_W  (SEL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    // Reference model: what each channel holds, whether a packet is open and where it goes.
    bit              occ  [N_OUT];
    bit [DATA_W-1:0] mdat [N_OUT];
    bit              mlst [N_OUT];
    bit              pkt_open;
    int              pkt_dest;
    int              mdrops;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_OUT; k++) begin
            occ[k]  = 1'b0;
            mdat[k] = '0;
            mlst[k] = 1'b0;
        end
        pkt_open = 1'b0;
        pkt_dest = 0;
        mdrops   = 0;
    endtask

    // Ready rule: stalled only when the destination channel is full and its sink is not ready.
    function automatic bit model_ready(input bit rn, input bit [SEL_W-1:0] s, input bit [N_OUT-1:0] ordy);
        int t;
        t = pkt_open ? pkt_dest : int'(s);
        if (!rn) return 1'b0;
        if (t >= N_OUT) return 1'b1;
        return !occ[t] || ordy[t];
    endfunction

    // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit v, input bit [DATA_W-1:0] d, input bit l,
                         input bit [SEL_W-1:0] s, input bit [N_OUT-1:0] ordy, input bit rn);
        bit                      rdy;
        int                      t;
        logic [N_OUT*DATA_W-1:0] exp_data;
        logic [N_OUT-1:0]        exp_v;
        logic [N_OUT-1:0]        exp_l;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.in_sel    = s;
        bus.out_ready = ordy;
        rst_n         = rn;
        @(negedge clk);
        rdy = model_ready(rn, s, ordy);
        for (int k = 0; k < N_OUT; k++) begin
            exp_v[k]                   = occ[k];
            exp_l[k]                   = mlst[k];
            exp_data[k*DATA_W +: DATA_W] = mdat[k];
        end
        chk("in_ready",  64'(bus.in_ready),  64'(rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
        chk("out_data",  64'(bus.out_data),  64'(exp_data));
        chk("out_last",  64'(bus.out_last),  64'(exp_l));
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("drop_cnt",  64'(drop_cnt),      64'(mdrops));
`endif
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            t = pkt_open ? pkt_dest : int'(s);
            for (int k = 0; k < N_OUT; k++) begin
                if (occ[k] && ordy[k]) occ[k] = 1'b0;
            end
            if (v && rdy) begin
                if (t < N_OUT) begin
                    occ[t]  = 1'b1;
                    mdat[t] = d;
                    mlst[t] = l;
                end else if (mdrops < 65535) begin
                    mdrops++;
                end
                if (!pkt_open && !l) begin
                    pkt_open = 1'b1;
                    pkt_dest = int'(s);
                end else if (pkt_open && l) begin
                    pkt_open = 1'b0;
                end
            end
        end
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();

        // Reset: in_ready low even with a valid beat, all outputs cleared.
        cycle(1'b1, 4'hF, 1'b1, 2'd0, 3'b111, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 2'd1, 3'b111, 1'b0);

        // Two single-beat packets to channels 1 then 0, then let them drain.
        cycle(1'b1, 4'hA, 1'b1, 2'd1, 3'b111, 1'b1);
        cycle(1'b1, 4'h5, 1'b1, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);

        // Three-beat packet: select only honoured on the first beat.
        cycle(1'b1, 4'h1, 1'b0, 2'd1, 3'b111, 1'b1);
        cycle(1'b1, 4'h2, 1'b0, 2'd0, 3'b111, 1'b1);
        cycle(1'b1, 4'h3, 1'b1, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);

        // Backpressure on channel 0: fill it, then a second beat waits until ready returns.
        cycle(1'b1, 4'h7, 1'b1, 2'd0, 3'b110, 1'b1);
        repeat (3) cycle(1'b1, 4'h8, 1'b1, 2'd0, 3'b110, 1'b1);
        // Other channels still flow while channel 0 is stalled.
        cycle(1'b1, 4'hC, 1'b1, 2'd2, 3'b110, 1'b1);
        cycle(1'b1, 4'h8, 1'b1, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);

        // Out-of-range select: two-beat packet swallowed, ready high, nothing written.
        cycle(1'b1, 4'h9, 1'b0, 2'd3, 3'b111, 1'b1);
        cycle(1'b1, 4'hB, 1'b1, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);

        // Full-throughput stream into channel 0.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, DATA_W'(i + 3), (i == 7), 2'd0, 3'b111, 1'b1);
        end
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);

        // Reset mid-packet, then a fresh packet start to channel 0.
        cycle(1'b1, 4'h1, 1'b0, 2'd1, 3'b111, 1'b1);
        cycle(1'b1, 4'h2, 1'b0, 2'd1, 3'b111, 1'b0);
        cycle(1'b1, 4'h4, 1'b1, 2'd0, 3'b111, 1'b1);
        cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);

        // Randomised traffic: random selects (including out of range), lengths, sink stalls, resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) != 0),
                  DATA_W'($urandom),
                  ($urandom_range(2) == 0),
                  SEL_W'($urandom_range(3)),
                  N_OUT'($urandom),
                  ($urandom_range(59) != 0));
        end

        // Drain everything with all sinks ready.
        repeat (3) cycle(1'b0, 4'h0, 1'b0, 2'd0, 3'b111, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DATA_W, default 4, payload width in bits (1..64).
REQ-002 Parameter N_OUT, default 2, number of output channels (2..16).
REQ-003 Parameter SEL_W, default $clog2(N_OUT) floored at 1, width of the select input.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 in_data  input  DATA_W  input payload.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_last  input  1  marks the final beat of a packet.
REQ-009 in_sel  input  SEL_W  destination channel index, sampled only on the first beat of a packet.
REQ-010 in_ready  output  1  the block accepts a beat this cycle.
REQ-011 out_data  output  N_OUT*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 out_valid  output  N_OUT  per-channel valid.
REQ-013 out_last  output  N_OUT  per-channel last flag.
REQ-014 out_ready  input  N_OUT  per-channel ready.
REQ-015 drop_cnt  output  16  count of dropped beats; present only when STREAM_DEMUX_DROP_CNT_EN is defined.

Function
REQ-016 A beat transfers on either side only when valid and ready are both 1 in the same cycle.
REQ-017 Each channel has a one-entry output register holding data, last and valid.
- out_* are driven only from that register.
- Latency from input accept to out_valid is exactly 1 cycle.
REQ-018 The FSM has two states:
- IDLE: no packet open.
- PKT: a packet is routed to the latched channel cur_sel.
REQ-019 Transitions out of IDLE:
- An accepted beat with in_last=0 latches cur_sel=in_sel and moves to PKT.
- An accepted beat with in_last=1 routes using in_sel and stays in IDLE.
REQ-020 In PKT, in_sel is ignored and every beat routes to cur_sel; an accepted beat with in_last=1 returns the FSM to IDLE.
REQ-021 in_ready = (target register empty) OR (target out_ready=1), where the target is in_sel in IDLE and cur_sel in PKT.
- This is a full-throughput pass-through: a register that is being drained in the same cycle can accept a new beat.
REQ-022 Outputs other than the target never change due to an input beat, so a stalled channel does not block traffic to other channels once the packet boundary is reached.
REQ-023 An out-of-range select (in_sel >= N_OUT, sampled per REQ-019) marks the packet as dropped:
- in_ready=1 for every beat of that packet.
- No output is written.
- The FSM still tracks in_last.
REQ-024 in_ready is combinational from in_sel, in_valid-independent state and out_ready; in_ready never depends on in_valid.
REQ-025 When an output register is drained and refilled in the same cycle, it holds the new beat and out_valid stays 1.

Reset
REQ-026 While rst_n=0 at a rising edge:
- FSM returns to IDLE.
- cur_sel=0.
- All out_valid=0.
- out_data and out_last=0.
- drop_cnt=0.
REQ-027 Reset in the middle of a packet discards the open packet and any buffered beats; the first accepted beat after reset is treated as a packet start.
REQ-028 in_ready is 0 during any cycle in which rst_n=0.

Configuration
REQ-029 With STREAM_DEMUX_DROP_CNT_EN defined:
- drop_cnt increments by 1 for each accepted dropped beat.
- It saturates at 16'hFFFF.
REQ-030 Without STREAM_DEMUX_DROP_CNT_EN, the drop_cnt port and its counter are absent; drop behaviour per REQ-023 is unchanged.

Structure
REQ-031 Package stream_demux_pkg holds:
- the FSM state typedef (ST_IDLE, ST_PKT);
- DROP_CNT_W=16;
- a select-width helper function.
REQ-032 Sub-module demux_out_reg (one instance per channel, via generate) implements the one-entry register with load, drain and same-cycle load-and-drain.

Verification
REQ-033 DATA_W=4, N_OUT=2, all out_ready=1. Single beats with in_sel=1 data=4'hA last=1, then in_sel=0 data=4'h5 last=1. Required response:
- out_valid[1]=1 with 4'hA on the next cycle.
- out_valid[0]=1 with 4'h5 on the cycle after that.
REQ-034 3-beat packet (data 1,2,3) with in_sel=1 on beat 1 and in_sel=0 on beats 2-3. All three beats appear on channel 1 only, with out_last=1 on beat 3.
REQ-035 out_ready[0]=0 with channel 0 full, then a new beat to channel 0. Required response:
- in_ready=0 until out_ready[0] is raised.
- No beat is lost or duplicated.
REQ-036 N_OUT=3, in_sel=3, 2-beat packet. Required response:
- in_ready=1 for both beats.
- No out_valid is asserted.
- drop_cnt=2 with the macro defined.
REQ-037 Continuous stream to channel 0 with out_ready[0]=1 held. One beat is accepted and delivered every cycle with no bubbles.
REQ-038 Assert rst_n=0 after beat 1 of a 3-beat packet. Required response:
- All out_valid=0 on the next cycle.
- After release, a beat with in_sel=0 routes to channel 0.
